inst_loop_seq: RTL
==================

INST_LOOP_SEQ -- requirements
Module: inst_loop_seq

Interface
REQ-001 SHALL have parameter InstAddrWidth, default 8, instruction-memory address width (matches 8-bit jump/end/count CSR fields).
REQ-002 SHALL have parameter NumLoops, default 3, number of nested loop levels (level 0 innermost).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle start pulse (CORE_SET start bit).
REQ-006 SHALL have port clr_i  input  1  synchronous soft clear (INST_CTRL clear bit).
REQ-007 SHALL have port stall_i  input  1  hold pc_o and all counters this cycle.
REQ-008 SHALL have port loop_mode_i  input  2  0 = linear, 1/2/3 = number of active nested loops.
REQ-009 SHALL have port jump_addr_i  input  NumLoops x InstAddrWidth  per-level loop start address.
REQ-010 SHALL have port end_addr_i  input  NumLoops x InstAddrWidth  per-level loop end address.
REQ-011 SHALL have port count_i  input  NumLoops x InstAddrWidth  per-level iteration count.
REQ-012 SHALL have port pc_o  output  InstAddrWidth  current instruction address.
REQ-013 SHALL have port pc_valid_o  output  1  pc_o valid for fetch this cycle.
REQ-014 SHALL have port busy_o  output  1  sequencer running (CORE_SET busy bit).
REQ-015 SHALL have port done_o  output  1  one-cycle pulse on program completion.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 IDLE: start_i -> RUN, pc_o=0, all loop counters=0; start_i in RUN/DONE SHALL be ignored.
REQ-018 RUN: pc_valid_o=1, busy_o=1; stall_i=1 freezes pc_o, counters, state.
REQ-019 RUN, not stalled: levels 0..loop_mode_i-1 evaluated innermost-first; first level k with pc_o==end_addr_i[k] and cnt[k]<count_i[k]-1 SHALL take jump: pc_o<=jump_addr_i[k], cnt[k]++, cnt[0..k-1]<=0.
REQ-020 Level k with pc_o==end_addr_i[k] and cnt[k]==count_i[k]-1 SHALL reset cnt[k]<=0 and fall through to level k+1 in the same cycle.
REQ-021 Completion: pc_o==end_addr_i[L-1] with level L-1 exhausted (L=loop_mode_i), or pc_o==end_addr_i[0] when loop_mode_i=0 -> DONE; otherwise pc_o<=pc_o+1.
REQ-022 count_i[k]==0 SHALL be treated as 1 (single pass, no jump).
REQ-023 pc_o increment SHALL wrap modulo 2^InstAddrWidth without error.
REQ-024 DONE: done_o=1 exactly one cycle, pc_valid_o=0, busy_o=1, next state IDLE.
REQ-025 IDLE: pc_valid_o=0, busy_o=0, done_o=0, pc_o holds last value.
REQ-026 clr_i SHALL take priority over start_i and stall_i: next state IDLE, pc_o=0, counters=0, no done_o.
REQ-027 Configuration inputs SHALL be sampled live each cycle; software changes them only while busy_o=0.

Reset
REQ-028 rst_ni=0 at a clock edge SHALL force IDLE, pc_o=0, counters=0, pc_valid_o=0, busy_o=0, done_o=0, including mid-RUN.

Configuration
REQ-029 With LOOP_SEQ_DBG_EN defined, SHALL add output loop_cnt_o (NumLoops x InstAddrWidth) mirroring cnt[] and output iter_total_o (32) counting taken jumps since start (reset on start/clr/rst_ni).
REQ-030 Without LOOP_SEQ_DBG_EN, these ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 FSM state enum and NumLoops/InstAddrWidth defaults SHALL live in a shared package alongside the CSR address constants.
REQ-032 Per-level counter/compare SHALL be a sub-module loop_level_cnt instantiated NumLoops times; fall-through chain in the top.

Verification
REQ-033 Linear: mode=0, end0=5, start -> pc 0..5 valid six cycles, done_o at cycle 7, busy_o low after.
REQ-034 Single loop: mode=1, jump0=2, end0=4, count0=3 -> pc 0,1,2,3,4,2,3,4,2,3,4 then done_o.
REQ-035 Nested: mode=2, j0=1,e0=2,c0=2, j1=0,e1=3,c1=2 -> pc 0,1,2,1,2,3,0,1,2,1,2,3 then done_o; shared end0=e1=3 case also passes.
REQ-036 Stall/zero count: stall_i high 3 cycles at pc=3 -> pc_o held 3, no counter change; count0=0 -> no jump.
REQ-037 clr_i at pc=4 and rst_ni low mid-loop -> IDLE next cycle, pc_o=0, no done_o; start_i while busy ignored.

Source files
------------

// File: rtl/inst_loop_seq_pkg.sv
// -----------------------------------------------------------------------------
// inst_loop_seq_pkg
// Shared definitions for the instruction loop sequencer:
//   - default widths (InstAddrWidth / NumLoops)
//   - sequencer FSM state encoding
//   - CSR address / bit constants for the registers that drive the sequencer
//   - helper that clamps the requested loop mode to the levels that exist
// Optional debug build: define LOOP_SEQ_DBG_EN (see inst_loop_seq.sv).
// -----------------------------------------------------------------------------
package inst_loop_seq_pkg;

   localparam int unsigned DefInstAddrWidth = 8;
   localparam int unsigned DefNumLoops      = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   // CSR map (byte addresses) and bit positions used by software.
   localparam logic [7:0] CSR_CORE_SET_ADDR   = 8'h00;
   localparam logic [7:0] CSR_INST_CTRL_ADDR  = 8'h04;
   localparam logic [7:0] CSR_LOOP_JUMP_ADDR  = 8'h08;
   localparam logic [7:0] CSR_LOOP_END_ADDR   = 8'h0C;
   localparam logic [7:0] CSR_LOOP_COUNT_ADDR = 8'h10;

   localparam int unsigned CORE_SET_START_BIT  = 0;
   localparam int unsigned CORE_SET_BUSY_BIT   = 1;
   localparam int unsigned INST_CTRL_CLEAR_BIT = 0;

   // Number of loop levels actually evaluated: the mode asks for up to 3,
   // but a build with fewer levels cannot honour more than it has.
   function automatic int active_levels(input logic [1:0] mode, input int num_loops);
      int m;
      m = int'(mode);
      return (m > num_loops) ? num_loops : m;
   endfunction

endpackage

// File: rtl/loop_level_cnt.sv
// -----------------------------------------------------------------------------
// loop_level_cnt
// One nested-loop level: iteration counter plus end-address compare.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   clr_i                zero the counter (start of program / soft clear)
//   inc_i                count one taken jump at this level
//   zero_i               zero the counter (level exhausted or outer jump)
//   pc_i                 current instruction address
//   end_addr_i, count_i  this level's loop end address and iteration count
//   take_jump_o          pc is at end and more iterations remain
//   exhausted_o          pc is at end and this was the last iteration
//   cnt_o                counter value (LOOP_SEQ_DBG_EN builds only)
// -----------------------------------------------------------------------------
module loop_level_cnt
   import inst_loop_seq_pkg::*;
#(
   parameter int unsigned W = DefInstAddrWidth
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic         zero_i,
   input  logic [W-1:0] pc_i,
   input  logic [W-1:0] end_addr_i,
   input  logic [W-1:0] count_i,
   output logic         take_jump_o,
   output logic         exhausted_o
`ifdef LOOP_SEQ_DBG_EN
   ,
   output logic [W-1:0] cnt_o
`endif
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] last_idx;
   logic         at_end;

   always_comb begin
      // A count of zero behaves as a single pass: last index is 0.
      last_idx    = (count_i == '0) ? '0 : (count_i - W'(1));
      at_end      = (pc_i == end_addr_i);
      // ">=" keeps a stale counter from ever re-looping if config moved under it.
      take_jump_o = at_end && (cnt_q < last_idx);
      exhausted_o = at_end && (cnt_q >= last_idx);

      cnt_d = cnt_q;
      if (clr_i || zero_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef LOOP_SEQ_DBG_EN
   assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/inst_loop_seq.sv
// -----------------------------------------------------------------------------
// inst_loop_seq
// Instruction-address sequencer with up to NumLoops nested hardware loops.
// IDLE -> RUN on start_i; RUN walks pc_o, taking loop jumps innermost-first;
// reaching the outermost active loop end (or end_addr_i[0] in linear mode)
// moves to DONE for one cycle, then back to IDLE.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   start_i            one-cycle start pulse (ignored unless IDLE)
//   clr_i              soft clear, beats start_i and stall_i
//   stall_i            freeze pc/counters/state while running
//   loop_mode_i        0 = linear, 1..3 = number of nested loops
//   jump_addr_i, end_addr_i, count_i   per-level loop config (level 0 innermost)
//   pc_o, pc_valid_o   fetch address and its qualifier
//   busy_o, done_o     running flag, completion pulse
//   state_o            current FSM state (seq_state_e encoding)
// Build option LOOP_SEQ_DBG_EN adds loop_cnt_o (per-level counters) and
// iter_total_o (taken jumps since start).
// -----------------------------------------------------------------------------
module inst_loop_seq
   import inst_loop_seq_pkg::*;
#(
   parameter int unsigned InstAddrWidth = DefInstAddrWidth,
   parameter int unsigned NumLoops      = DefNumLoops
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   start_i,
   input  logic                                   clr_i,
   input  logic                                   stall_i,
   input  logic [1:0]                             loop_mode_i,
   input  logic [NumLoops-1:0][InstAddrWidth-1:0] jump_addr_i,
   input  logic [NumLoops-1:0][InstAddrWidth-1:0] end_addr_i,
   input  logic [NumLoops-1:0][InstAddrWidth-1:0] count_i,
   output logic [InstAddrWidth-1:0]               pc_o,
   output logic                                   pc_valid_o,
   output logic                                   busy_o,
   output logic [1:0]                             state_o,
   output logic                                   done_o
`ifdef LOOP_SEQ_DBG_EN
   ,
   output logic [NumLoops-1:0][InstAddrWidth-1:0] loop_cnt_o,
   output logic [31:0]                            iter_total_o
`endif
);

   seq_state_e               state_q, state_d;
   logic [InstAddrWidth-1:0] pc_q, pc_d;
   logic                     pc_valid_q, pc_valid_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic [NumLoops-1:0]      take_jump, exhausted;
   logic [NumLoops-1:0]      cnt_inc, cnt_zero;
   logic                     cnt_clr;
   logic                     decided;
   logic                     finish;
   int                       levels;

`ifdef LOOP_SEQ_DBG_EN
   logic [31:0]              iter_total_q, iter_total_d;
`endif

   for (genvar k = 0; k < NumLoops; k++) begin : g_level
      loop_level_cnt #(.W(InstAddrWidth)) u_level (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .clr_i       (cnt_clr),
         .inc_i       (cnt_inc[k]),
         .zero_i      (cnt_zero[k]),
         .pc_i        (pc_q),
         .end_addr_i  (end_addr_i[k]),
         .count_i     (count_i[k]),
         .take_jump_o (take_jump[k]),
         .exhausted_o (exhausted[k])
`ifdef LOOP_SEQ_DBG_EN
         ,
         .cnt_o       (loop_cnt_o[k])
`endif
      );
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cnt_inc  = '0;
      cnt_zero = '0;
      cnt_clr  = 1'b0;
      decided  = 1'b0;
      finish   = 1'b0;
      levels   = active_levels(loop_mode_i, int'(NumLoops));

      if (clr_i) begin
         state_d = ST_IDLE;
         pc_d    = '0;
         cnt_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d = ST_RUN;
                  pc_d    = '0;
                  cnt_clr = 1'b1;
               end
            end
            ST_RUN: begin
               if (!stall_i) begin
                  if (levels == 0) begin
                     finish = (pc_q == end_addr_i[0]);
                  end else begin
                     // Fall-through chain: exhausted levels reset and hand
                     // over to the next outer level in the same cycle; the
                     // first level with iterations left takes its jump.
                     for (int k = 0; k < int'(NumLoops); k++) begin
                        if (k < levels && !decided) begin
                           if (take_jump[k]) begin
                              pc_d       = jump_addr_i[k];
                              cnt_inc[k] = 1'b1;
                              for (int j = 0; j < int'(NumLoops); j++) begin
                                 if (j < k) cnt_zero[j] = 1'b1;
                              end
                              decided = 1'b1;
                           end else if (exhausted[k]) begin
                              cnt_zero[k] = 1'b1;
                              if (k == levels - 1) finish = 1'b1;
                           end
                        end
                     end
                  end

                  if (finish) begin
                     state_d = ST_DONE;
                  end else if (!decided) begin
                     pc_d = pc_q + InstAddrWidth'(1);
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are registered: they follow the state being entered.
      pc_valid_d = (state_d == ST_RUN);
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);

`ifdef LOOP_SEQ_DBG_EN
      iter_total_d = iter_total_q;
      if (cnt_clr) begin
         iter_total_d = '0;
      end else if (|cnt_inc) begin
         iter_total_d = iter_total_q + 32'd1;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         pc_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef LOOP_SEQ_DBG_EN
         iter_total_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_valid_q   <= pc_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef LOOP_SEQ_DBG_EN
         iter_total_q <= iter_total_d;
`endif
      end
   end

   assign pc_o       = pc_q;
   assign pc_valid_o = pc_valid_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign state_o    = state_q;

`ifdef LOOP_SEQ_DBG_EN
   assign iter_total_o = iter_total_q;
`endif

endmodule
